// File: rtl/led_drv_pkg.sv
// Shared types and elaboration-time helpers for the LED event driver.
package led_drv_pkg;

  // Per-channel sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } ch_state_t;

  // Width of a blink count and of the remaining-blinks counter.
  localparam int BLINK_W = 3;

  // Tick timers are never narrower than this.
  localparam int MIN_TIMER_W = 8;

  // Clock cycles per timing tick.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Timer width able to hold the longest phase length, at least MIN_TIMER_W.
  function automatic int calc_timer_w(input int hold_ticks, input int blink_ticks);
    int longest;
    int need;
    longest = (hold_ticks > blink_ticks) ? hold_ticks : blink_ticks;
    need    = $clog2(longest + 1);
    return (need > MIN_TIMER_W) ? need : MIN_TIMER_W;
  endfunction

endpackage

// File: rtl/led_stretch_channel.sv
// One LED channel: turns an event pulse into a stretched pulse or a counted
// blink burst, queues one further event, and flags events it had to drop.
module led_stretch_channel
  import led_drv_pkg::*;
#(
  parameter int HOLD_TICKS  = 50,
  parameter int BLINK_TICKS = 100,
  parameter int TIMER_W     = calc_timer_w(HOLD_TICKS, BLINK_TICKS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               event_i,
  input  logic [BLINK_W-1:0] blinks_i,
  input  logic               level_i,
  input  logic               clr_i,
  output logic               led_o,
  output logic               busy_o,
  output logic               overrun_o
);

  ch_state_t            state, state_n;
  logic [TIMER_W-1:0]   timer, timer_n;
  logic [BLINK_W-1:0]   rem, rem_n;
  logic                 pend_v, pend_v_n;
  logic [BLINK_W-1:0]   pend_cnt, pend_cnt_n;
  logic                 led_q, led_n;
  logic                 ovr_q;
  logic                 ovr_set;
  logic                 seq_end;
  logic                 do_start;
  logic [BLINK_W-1:0]   start_cnt;

  // Next-state, timer, pending-buffer and LED decode for this channel.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    state_n    = state;
    timer_n    = timer;
    rem_n      = rem;
    pend_v_n   = pend_v;
    pend_cnt_n = pend_cnt;
    ovr_set    = 1'b0;
    seq_end    = 1'b0;
    do_start   = 1'b0;
    start_cnt  = blinks_i;
    led_n      = 1'b0;

    case (state)
      IDLE: begin
        if (event_i) do_start = 1'b1;
      end
      ON: begin
        if (tick) begin
          if (timer == TIMER_W'(1)) begin
            if (rem == '0) begin
              seq_end = 1'b1;
            end else begin
              state_n = OFF;
              timer_n = TIMER_W'(BLINK_TICKS);
            end
          end else begin
            timer_n = timer - TIMER_W'(1);
          end
        end
      end
      OFF: begin
        if (tick) begin
          if (timer == TIMER_W'(1)) begin
            rem_n = rem - BLINK_W'(1);
            if (rem != BLINK_W'(1)) begin
              state_n = ON;
              timer_n = TIMER_W'(BLINK_TICKS);
            end else begin
              seq_end = 1'b1;
            end
          end else begin
            timer_n = timer - TIMER_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A finishing sequence hands over to the pending entry, or to an event
    // arriving in the same cycle, without passing through IDLE.
    if (seq_end) begin
      if (pend_v) begin
        do_start  = 1'b1;
        start_cnt = pend_cnt;
        pend_v_n  = event_i;
        if (event_i) pend_cnt_n = blinks_i;
      end else if (event_i) begin
        do_start = 1'b1;
      end else begin
        state_n = IDLE;
      end
    end else if ((state != IDLE) && event_i) begin
      if (!pend_v) begin
        pend_v_n   = 1'b1;
        pend_cnt_n = blinks_i;
      end else begin
        ovr_set = 1'b1;
      end
    end

    if (do_start) begin
      state_n = ON;
      rem_n   = start_cnt;
      timer_n = (start_cnt == '0) ? TIMER_W'(HOLD_TICKS) : TIMER_W'(BLINK_TICKS);
    end

    // LED follows the state being entered, so an event lights it one edge later.
    if (state_n == ON)        led_n = 1'b1;
    else if (state_n == OFF)  led_n = 1'b0;
    else                      led_n = level_i;
  end

  // State, timers, pending entry, LED and sticky overrun registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Reset drops any running or pending sequence so nothing resumes.
      state    <= IDLE;
      timer    <= '0;
      rem      <= '0;
      pend_v   <= 1'b0;
      pend_cnt <= '0;
      led_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state    <= state_n;
      timer    <= timer_n;
      rem      <= rem_n;
      pend_v   <= pend_v_n;
      pend_cnt <= pend_cnt_n;
      led_q    <= led_n;
      if (ovr_set)     ovr_q <= 1'b1;
      else if (clr_i)  ovr_q <= 1'b0;
    end
  end

  assign led_o     = led_q;
  assign busy_o    = (state != IDLE);
  assign overrun_o = ovr_q;

endmodule

// File: rtl/led_event_driver.sv
// LED event driver: shared tick prescaler feeding NUM_CH independent
// pulse-stretch / blink channels.
module led_event_driver
  import led_drv_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int NUM_CH      = 4,
  parameter int HOLD_TICKS  = 50,
  parameter int BLINK_TICKS = 100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         event_i,
  input  logic [BLINK_W*NUM_CH-1:0] blinks_i,
  input  logic [NUM_CH-1:0]         level_i,
  input  logic                      clr_i,
  output logic [NUM_CH-1:0]         led_o,
  output logic [NUM_CH-1:0]         busy_o,
  output logic [NUM_CH-1:0]         overrun_o
);

  localparam int DIV     = calc_div(CLK_HZ, TICK_HZ);
  localparam int CNT_W   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int TIMER_W = calc_timer_w(HOLD_TICKS, BLINK_TICKS);

  logic [CNT_W-1:0] presc_cnt;
  logic             tick;

  // Tick is high in the last cycle of each DIV-cycle period.
  assign tick = (presc_cnt == CNT_W'(DIV - 1));

  // Free-running prescaler 0..DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     presc_cnt <= '0;
    else if (tick)  presc_cnt <= '0;
    else            presc_cnt <= presc_cnt + CNT_W'(1);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_stretch_channel #(
      .HOLD_TICKS  (HOLD_TICKS),
      .BLINK_TICKS (BLINK_TICKS),
      .TIMER_W     (TIMER_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .event_i   (event_i[g]),
      .blinks_i  (blinks_i[g*BLINK_W +: BLINK_W]),
      .level_i   (level_i[g]),
      .clr_i     (clr_i),
      .led_o     (led_o[g]),
      .busy_o    (busy_o[g]),
      .overrun_o (overrun_o[g])
    );
  end

endmodule

// File: tb/tb_led_event_driver.sv
// Self-checking bench for led_event_driver with DIV=10, two channels,
// HOLD_TICKS=5 and BLINK_TICKS=2.
module tb_led_event_driver;

  localparam int CLK_HZ      = 1000;
  localparam int TICK_HZ     = 100;
  localparam int NUM_CH      = 2;
  localparam int HOLD_TICKS  = 5;
  localparam int BLINK_TICKS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] event_i = '0;
  logic [5:0] blinks_i = '0;
  logic [1:0] level_i = '0;
  logic       clr_i = 1'b0;
  logic [1:0] led_o;
  logic [1:0] busy_o;
  logic [1:0] overrun_o;

  led_event_driver #(
    .CLK_HZ      (CLK_HZ),
    .TICK_HZ     (TICK_HZ),
    .NUM_CH      (NUM_CH),
    .HOLD_TICKS  (HOLD_TICKS),
    .BLINK_TICKS (BLINK_TICKS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .event_i   (event_i),
    .blinks_i  (blinks_i),
    .level_i   (level_i),
    .clr_i     (clr_i),
    .led_o     (led_o),
    .busy_o    (busy_o),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ev;
    logic [5:0] bl;
    logic [1:0] lv;
    logic       clr;
    logic [1:0] e_led;
    logic [1:0] e_busy;
    logic [1:0] e_ovr;
  } vec_t;

  typedef struct {
    int         idx;
    logic [1:0] led;
    logic [1:0] busy;
    logic [1:0] ovr;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  exp_t e;

  int n_checks = 0;
  int n_pass   = 0;

  // Pulse-train trace state.
  int   rises, last_edge, busy_end;
  logic prev_led, busy_back;
  int   hi_q[$];
  int   lo_q[$];

  int   first_tick, n_ticks, bad_ticks, quiet_bad, mism, other_hit, wait_n;
  logic first_ok, lv0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] bl_val(input logic ch, input int n);
    logic [5:0] v;
    v = '0;
    if (ch) v[5:3] = n[2:0];
    else    v[2:0] = n[2:0];
    return v;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    wait_n = 0;
    while (busy_o !== 2'b00 && wait_n < budget) begin
      step();
      wait_n++;
    end
    check(name, 32'(busy_o), 32'd0);
  endtask

  task automatic trace_reset();
    rises     = 0;
    last_edge = 0;
    busy_end  = -1;
    prev_led  = 1'b0;
    busy_back = 1'b0;
    hi_q.delete();
    lo_q.delete();
  endtask

  task automatic trace_sample(input logic ch, input int c);
    logic l;
    logic b;
    l = led_o[ch];
    b = busy_o[ch];
    if (l && !prev_led) begin
      rises++;
      if (rises > 1) lo_q.push_back(c - last_edge);
      last_edge = c;
    end else if (!l && prev_led) begin
      hi_q.push_back(c - last_edge);
      last_edge = c;
    end
    if (!b && busy_end < 0) busy_end = c;
    if (b && busy_end >= 0) busy_back = 1'b1;
    prev_led = l;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{ev:2'b00, bl:6'o00, lv:2'b00, clr:1'b0, e_led:2'b00, e_busy:2'b00, e_ovr:2'b00};
    vecs[1] = '{ev:2'b00, bl:6'o00, lv:2'b01, clr:1'b0, e_led:2'b01, e_busy:2'b00, e_ovr:2'b00};
    vecs[2] = '{ev:2'b00, bl:6'o00, lv:2'b10, clr:1'b0, e_led:2'b10, e_busy:2'b00, e_ovr:2'b00};
    vecs[3] = '{ev:2'b00, bl:6'o00, lv:2'b11, clr:1'b0, e_led:2'b11, e_busy:2'b00, e_ovr:2'b00};
    vecs[4] = '{ev:2'b00, bl:6'o00, lv:2'b00, clr:1'b0, e_led:2'b00, e_busy:2'b00, e_ovr:2'b00};
    vecs[5] = '{ev:2'b01, bl:6'o00, lv:2'b00, clr:1'b0, e_led:2'b01, e_busy:2'b01, e_ovr:2'b00};
    vecs[6] = '{ev:2'b00, bl:6'o00, lv:2'b10, clr:1'b0, e_led:2'b11, e_busy:2'b01, e_ovr:2'b00};
    vecs[7] = '{ev:2'b00, bl:6'o00, lv:2'b00, clr:1'b1, e_led:2'b01, e_busy:2'b01, e_ovr:2'b00};
    vecs[8] = '{ev:2'b10, bl:6'o10, lv:2'b00, clr:1'b0, e_led:2'b11, e_busy:2'b11, e_ovr:2'b00};
    vecs[9] = '{ev:2'b00, bl:6'o00, lv:2'b00, clr:1'b0, e_led:2'b11, e_busy:2'b11, e_ovr:2'b00};

    // Reset state, then release and watch the prescaler tick.
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", 32'(led_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ovr", 32'(overrun_o), 32'd0);
    rst_n = 1'b1;

    first_tick = -1;
    n_ticks    = 0;
    bad_ticks  = 0;
    quiet_bad  = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (dut.tick === 1'b1) begin
        n_ticks++;
        if (first_tick < 0) first_tick = i;
        if (i % 10 != 0) bad_ticks++;
      end else if (i % 10 == 0) begin
        bad_ticks++;
      end
      if (led_o !== 2'b00 || busy_o !== 2'b00 || overrun_o !== 2'b00) quiet_bad++;
    end
    check("tick_first_cycle", 32'(first_tick), 32'd10);
    check("tick_count_30cyc", 32'(n_ticks), 32'd3);
    check("tick_period", 32'(bad_ticks), 32'd0);
    check("quiet_outputs", 32'(quiet_bad), 32'd0);
    step();

    // Cycle-exact vectors: level latency, event latency, channel independence.
    for (int i = 0; i < 10; i++) begin
      event_i  = vecs[i].ev;
      blinks_i = vecs[i].bl;
      level_i  = vecs[i].lv;
      clr_i    = vecs[i].clr;
      sb.push_back('{idx: i, led: vecs[i].e_led, busy: vecs[i].e_busy, ovr: vecs[i].e_ovr});
      step();
      e = sb.pop_front();
      check($sformatf("tbl%0d_led", e.idx), 32'(led_o), 32'(e.led));
      check($sformatf("tbl%0d_busy", e.idx), 32'(busy_o), 32'(e.busy));
      check($sformatf("tbl%0d_ovr", e.idx), 32'(overrun_o), 32'(e.ovr));
    end
    event_i = '0; blinks_i = '0; level_i = '0; clr_i = 1'b0;
    wait_idle("idle_after_table", 120);

    // Single stretched pulse on ch0.
    trace_reset();
    other_hit = 0;
    first_ok  = 1'b0;
    for (int c = 0; c < 70; c++) begin
      if (c == 0) begin event_i = 2'b01; blinks_i = bl_val(1'b0, 0); end
      step();
      event_i = '0;
      if (c == 0) first_ok = led_o[0] & busy_o[0];
      trace_sample(1'b0, c);
      if (led_o[1] !== 1'b0 || busy_o[1] !== 1'b0) other_hit++;
    end
    check("hold_first_cycle", 32'(first_ok), 32'd1);
    check("hold_rises", 32'(rises), 32'd1);
    check_range("hold_high_len", (hi_q.size() > 0) ? hi_q[0] : 0, 41, 50);
    check("hold_busy_falls_with_led", 32'(busy_end), 32'(last_edge));
    check("hold_ch1_untouched", 32'(other_hit), 32'd0);

    // Three-blink burst on ch1.
    trace_reset();
    for (int c = 0; c < 150; c++) begin
      if (c == 0) begin event_i = 2'b10; blinks_i = bl_val(1'b1, 3); end
      step();
      event_i = '0;
      trace_sample(1'b1, c);
    end
    check("blink3_rises", 32'(rises), 32'd3);
    check("blink3_high_count", 32'(hi_q.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      check_range($sformatf("blink3_high%0d", k), (hi_q.size() > k) ? hi_q[k] : 0, 11, 20);
    check("blink3_low_count", 32'(lo_q.size()), 32'd2);
    for (int k = 0; k < 2; k++)
      check($sformatf("blink3_low%0d", k), 32'((lo_q.size() > k) ? lo_q[k] : 0), 32'd20);
    check("blink3_last_off", 32'(busy_end - last_edge), 32'd20);
    check("blink3_no_restart", 32'(busy_back), 32'd0);

    // Pending hand-over and overrun on ch0.
    trace_reset();
    for (int c = 0; c < 160; c++) begin
      if (c == 0)       begin event_i = 2'b01; blinks_i = bl_val(1'b0, 0); end
      else if (c == 5)  begin event_i = 2'b01; blinks_i = bl_val(1'b0, 2); end
      else if (c == 10) begin event_i = 2'b01; blinks_i = bl_val(1'b0, 1); end
      step();
      event_i = '0;
      trace_sample(1'b0, c);
      if (c == 5)  check("pend_store_no_ovr", 32'(overrun_o[0]), 32'd0);
      if (c == 10) check("pend_drop_sets_ovr", 32'(overrun_o[0]), 32'd1);
    end
    check("pend_rises", 32'(rises), 32'd2);
    check_range("pend_merged_high", (hi_q.size() > 0) ? hi_q[0] : 0, 61, 70);
    check("pend_second_high", 32'((hi_q.size() > 1) ? hi_q[1] : 0), 32'd20);
    check("pend_low", 32'((lo_q.size() > 0) ? lo_q[0] : 0), 32'd20);
    check("pend_last_off", 32'(busy_end - last_edge), 32'd20);
    check("pend_dropped_never_runs", 32'(busy_back), 32'd0);

    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check("clr_clears_ovr", 32'(overrun_o[0]), 32'd0);
    event_i = 2'b01; blinks_i = bl_val(1'b0, 0);
    step();
    step();
    clr_i = 1'b1;
    step();
    event_i = '0; clr_i = 1'b0;
    check("ovr_set_beats_clr", 32'(overrun_o[0]), 32'd1);
    step();
    check("ovr_sticky", 32'(overrun_o[0]), 32'd1);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check("ovr_cleared_again", 32'(overrun_o[0]), 32'd0);
    wait_idle("idle_after_pend", 200);

    // Level display, then asynchronous reset in the middle of a burst.
    level_i = 2'b01;
    step();
    check("level_latency", 32'(led_o[0]), 32'd1);
    event_i = 2'b01; blinks_i = bl_val(1'b0, 3);
    step();
    step();
    step();
    event_i = '0;
    repeat (25) step();
    check("pre_rst_busy", 32'(busy_o[0]), 32'd1);
    check("pre_rst_ovr", 32'(overrun_o[0]), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(led_o), 32'd0);
    check("async_rst_busy", 32'(busy_o), 32'd0);
    check("async_rst_ovr", 32'(overrun_o), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mism = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 30) level_i = 2'b00;
      lv0 = level_i[0];
      step();
      if (led_o !== {1'b0, lv0}) mism++;
      if (busy_o !== 2'b00 || overrun_o !== 2'b00) mism++;
    end
    check("post_rst_level_only", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
